buffer_wr_arbiter: RTL and testbench



---
 rtl/buffer_wr_arbiter.sv | 84 ++++++++
 tb/tb_buffer_wr_arbiter.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/buffer_wr_arbiter.sv
// Round-robin arbiter sharing the buffer's single write port among NUM_REQ requesters.
// Registered wr_en/wr_addr/wr_data feed the buffer directly; ack pulses one cycle per issued write.
module buffer_wr_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int ADDR_W  = 8,
   parameter int DATA_W  = 32,
   parameter int LOG_REQ = 2
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        stall,
   input  logic [NUM_REQ-1:0]          req,
   input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
   input  logic [NUM_REQ*DATA_W-1:0]   req_data,
   output logic [NUM_REQ-1:0]          ack,
   output logic                        wr_en,
   output logic [ADDR_W-1:0]           wr_addr,
   output logic [DATA_W-1:0]           wr_data,
   output logic [LOG_REQ-1:0]          grant_id,
   output logic                        busy
);

   logic [LOG_REQ-1:0] rr_ptr;
   logic [LOG_REQ-1:0] win_idx;
   logic [LOG_REQ-1:0] next_ptr;
   logic               win_valid;
   logic [NUM_REQ-1:0] elig;
   logic [ADDR_W-1:0]  sel_addr;
   logic [DATA_W-1:0]  sel_data;

   // The requester acked this cycle is masked so a held req is not granted twice.
   assign elig = req & ~ack;
   assign busy = |elig;

   always_comb begin
      logic [LOG_REQ-1:0] cand;
      cand      = '0;
      win_valid = 1'b0;
      win_idx   = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         cand = LOG_REQ'((32'(rr_ptr) + i) % NUM_REQ);
         if (!win_valid && elig[cand]) begin
            win_valid = 1'b1;
            win_idx   = cand;
         end
      end
   end

   always_comb begin
      sel_addr = '0;
      sel_data = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (win_idx == LOG_REQ'(i)) begin
            sel_addr = req_addr[i*ADDR_W +: ADDR_W];
            sel_data = req_data[i*DATA_W +: DATA_W];
         end
      end
   end

   assign next_ptr = (win_idx == LOG_REQ'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_en    <= 1'b0;
         ack      <= '0;
         wr_addr  <= '0;
         wr_data  <= '0;
         grant_id <= '0;
         rr_ptr   <= '0;
      end else if (win_valid && !stall) begin
         wr_en        <= 1'b1;
         ack          <= '0;
         ack[win_idx] <= 1'b1;
         wr_addr      <= sel_addr;
         wr_data      <= sel_data;
         grant_id     <= win_idx;
         rr_ptr       <= next_ptr;
      end else begin
         wr_en <= 1'b0;
         ack   <= '0;
      end
   end

endmodule

// File: tb/tb_buffer_wr_arbiter.sv
// Bench for buffer_wr_arbiter: directed vectors with literal expectations plus a
// per-cycle comparison against a grant-order model and a small buffer model.
module tb_buffer_wr_arbiter;

   localparam int N  = 4;
   localparam int AW = 8;
   localparam int DW = 32;

   logic            clk = 1'b0;
   logic            reset;
   logic            stall;
   logic [N-1:0]    req;
   logic [N*AW-1:0] req_addr;
   logic [N*DW-1:0] req_data;
   logic [N-1:0]    ack;
   logic            wr_en;
   logic [AW-1:0]   wr_addr;
   logic [DW-1:0]   wr_data;
   logic [1:0]      grant_id;
   logic            busy;

   int checks = 0;
   int errors = 0;

   buffer_wr_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .LOG_REQ(2)) dut (
      .clk(clk), .reset(reset), .stall(stall), .req(req),
      .req_addr(req_addr), .req_data(req_data), .ack(ack),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .grant_id(grant_id), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
      end
   endtask

   // Behavioural model: next grant is the nearest requesting, not-just-acked
   // client at or after the saved priority position, wrapping around.
   int           m_ptr = 0;
   logic [N-1:0] m_ack = '0;
   logic         m_wr_en = 1'b0;
   logic [AW-1:0] m_addr = '0;
   logic [DW-1:0] m_data = '0;
   int           m_gid = 0;
   bit           m_live = 0;

   always @(posedge clk) begin
      if (reset) begin
         m_ptr = 0; m_ack = '0; m_wr_en = 1'b0; m_addr = '0; m_data = '0; m_gid = 0;
         m_live = 1;
      end else begin
         int w;
         w = -1;
         for (int k = 0; k < N; k++) begin
            int c;
            c = (m_ptr + k) % N;
            if (w < 0 && req[c] && !m_ack[c]) w = c;
         end
         if (w >= 0 && !stall) begin
            m_wr_en = 1'b1;
            m_ack   = '0;
            m_ack[w] = 1'b1;
            m_addr  = req_addr[w*AW +: AW];
            m_data  = req_data[w*DW +: DW];
            m_gid   = w;
            m_ptr   = (w + 1) % N;
         end else begin
            m_wr_en = 1'b0;
            m_ack   = '0;
         end
      end
   end

   // Buffer with a registered write port, as the arbiter's outputs would drive it.
   logic [DW-1:0] mem [256];
   always @(posedge clk) if (wr_en) mem[wr_addr] <= wr_data;

   always begin
      @(posedge clk);
      #1;
      if (m_live) begin
         logic [N-1:0] e;
         e = req & ~m_ack;
         chk("wr_en",    wr_en,    m_wr_en);
         chk("ack",      ack,      m_ack);
         chk("wr_addr",  wr_addr,  m_addr);
         chk("wr_data",  wr_data,  m_data);
         chk("grant_id", grant_id, m_gid[1:0]);
         chk("busy",     busy,     |e);
         chk("ack_onehot", 64'($countones(ack) <= 1), 64'd1);
      end
   end

   task automatic tick;
      @(posedge clk);
      #2;
   endtask

   task automatic set_slot(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
      req_addr[i*AW +: AW] = a;
      req_data[i*DW +: DW] = d;
   endtask

   initial begin
      int prev_ack1;
      reset = 1'b1; stall = 1'b0; req = 4'b1111;
      req_addr = '0; req_data = '0;
      for (int i = 0; i < N; i++) set_slot(i, AW'(8'h20 + i), DW'(32'hC0 + i));

      // Reset held two edges with all requesting: everything zero.
      for (int k = 0; k < 2; k++) begin
         tick;
         chk("rst_wr_en", wr_en, 0);
         chk("rst_ack", ack, 0);
         chk("rst_addr", wr_addr, 0);
         chk("rst_data", wr_data, 0);
         chk("rst_gid", grant_id, 0);
      end
      reset = 1'b0;
      tick;
      chk("first_gid", grant_id, 0);
      chk("first_ack", ack, 4'b0001);
      chk("first_addr", wr_addr, 8'h20);
      req = '0;
      tick;
      chk("idle_wr_en", wr_en, 0);

      // Single request from client 2 (priority now at 1).
      set_slot(2, 8'h05, 32'h0000_00A5);
      req = 4'b0100;
      tick;
      chk("single_wr_en", wr_en, 1);
      chk("single_addr", wr_addr, 8'h05);
      chk("single_data", wr_data, 32'h0000_00A5);
      chk("single_ack", ack, 4'b0100);
      chk("single_gid", grant_id, 2);
      req = '0;
      tick;
      chk("single_drop", wr_en, 0);
      chk("single_hold_addr", wr_addr, 8'h05);
      chk("buf_rd_5", mem[5], 32'h0000_00A5);

      // Round robin after a reset: 0,1,2,3,0,... one write every cycle.
      reset = 1'b1;
      tick;
      reset = 1'b0;
      for (int i = 0; i < N; i++) set_slot(i, AW'(8'h10 + i), DW'(32'hD0 + i));
      req = 4'b1111;
      for (int k = 0; k < 8; k++) begin
         tick;
         chk("rr_wr_en", wr_en, 1);
         chk("rr_gid", grant_id, k % 4);
         chk("rr_addr", wr_addr, 8'h10 + k % 4);
         chk("rr_ack", ack, 4'b0001 << (k % 4));
      end

      // Lone requester gets every other cycle.
      req = 4'b0010;
      prev_ack1 = 0;
      for (int k = 0; k < 6; k++) begin
         tick;
         chk("mask_ack1", ack[1], (k % 2 == 0));
         chk("mask_no_consec", 64'(prev_ack1 && ack[1]), 0);
         prev_ack1 = ack[1];
      end
      req = '0;
      tick;

      // Stall holds off grants; priority (now 2) resumes at client 0 then 1.
      req = 4'b0011; stall = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick;
         chk("stall_wr_en", wr_en, 0);
         chk("stall_ack", ack, 0);
      end
      stall = 1'b0;
      tick;
      chk("resume_gid0", grant_id, 0);
      chk("resume_wr_en", wr_en, 1);
      tick;
      chk("resume_gid1", grant_id, 1);
      req = '0;
      tick;

      // Reset in the same cycle client 3 requests: dropped, pointer cleared.
      req = 4'b1000; reset = 1'b1;
      tick;
      chk("midrst_wr_en", wr_en, 0);
      chk("midrst_ack", ack, 0);
      reset = 1'b0;
      req = 4'b1010;
      tick;
      chk("midrst_ptr0_gid", grant_id, 1);
      chk("midrst_ack1", ack, 4'b0010);
      req = '0;
      tick;

      // Top address passes through untouched.
      set_slot(0, 8'hFF, 32'hFFFF_FFFF);
      req = 4'b0001;
      tick;
      chk("maxaddr_addr", wr_addr, 8'hFF);
      chk("maxaddr_data", wr_data, 32'hFFFF_FFFF);
      req = '0;
      tick;
      tick;
      chk("buf_rd_ff", mem[255], 32'hFFFF_FFFF);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
